// File: rtl/spike_window_arbiter.sv
// Spike-output scheduler: captures per-neuron requests over a trigger window, then
// issues them one-hot, round-robin, on a valid/ack handshake, followed by a cooldown.
//
// state  | meaning
// IDLE   | armed, waiting for a rising i_spike_in
// WINDOW | OR-collecting i_spike until P_WINDOW samples are taken
// ARB    | picks the first winner, or skips to COOL if nothing was captured
// GRANT  | holding a grant; each ack loads the next winner or ends the event
// COOL   | P_COOLDOWN idle clocks before re-arming
module spike_window_arbiter #(
    parameter int P_NUM      = 10,
    parameter int P_WINDOW   = 2,
    parameter int P_COOLDOWN = 1,
    localparam int IW   = $clog2(P_NUM),
    localparam int CMAX = (P_WINDOW > P_COOLDOWN) ? P_WINDOW : P_COOLDOWN,
    localparam int CW   = $clog2(CMAX + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_spike_in,
    input  logic [P_NUM-1:0] i_spike,
    input  logic             i_ack,
    output logic [P_NUM-1:0] o_spike,
    output logic [IW-1:0]    o_idx,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_drop
);

    typedef enum logic [2:0] {IDLE, WINDOW, ARB, GRANT, COOL} state_t;

    localparam logic [P_NUM-1:0] ONE = P_NUM'(1);

    state_t           state_q, state_d;
    logic [P_NUM-1:0] pend_q, pend_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [P_NUM-1:0] spike_q, spike_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             drop_q, drop_d;
    logic             spike_in_q;

    logic             rise;
    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic [CW-1:0]    cnt_inc;

    assign rise    = i_spike_in & ~spike_in_q;
    assign cnt_inc = cnt_q + CW'(1);

    // Round-robin search: first pending bit at or above rr_q, wrapping past P_NUM-1.
    always_comb begin
        int pos;
        win_found = 1'b0;
        win_idx   = '0;
        pos       = 0;
        for (int k = 0; k < P_NUM; k++) begin
            pos = int'(rr_q) + k;
            if (pos >= P_NUM) pos = pos - P_NUM;
            if (!win_found && pend_q[pos[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = pos[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        spike_d = spike_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        drop_d  = rise & (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (rise) begin
                    pend_d  = i_spike;
                    cnt_d   = CW'(1);
                    state_d = (P_WINDOW == 1) ? ARB : WINDOW;
                end
            end
            WINDOW: begin
                pend_d = pend_q | i_spike;
                cnt_d  = cnt_inc;
                if (cnt_inc == CW'(P_WINDOW)) state_d = ARB;
            end
            ARB, GRANT: begin
                if (state_q == ARB || i_ack) begin
                    if (win_found) begin
                        spike_d = ONE << win_idx;
                        idx_d   = win_idx;
                        valid_d = 1'b1;
                        pend_d  = pend_q & ~(ONE << win_idx);
                        rr_d    = (win_idx == IW'(P_NUM - 1)) ? '0 : win_idx + IW'(1);
                        state_d = GRANT;
                    end else begin
                        valid_d = 1'b0;
                        spike_d = '0;
                        cnt_d   = '0;
                        state_d = COOL;
                    end
                end
            end
            COOL: begin
                if (cnt_inc >= CW'(P_COOLDOWN)) state_d = IDLE;
                else cnt_d = cnt_inc;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            rr_q       <= '0;
            cnt_q      <= '0;
            spike_q    <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
            spike_in_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            spike_q    <= spike_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            drop_q     <= drop_d;
            spike_in_q <= i_spike_in;
        end
    end

    assign o_spike = spike_q;
    assign o_idx   = idx_q;
    assign o_valid = valid_q;
    assign o_busy  = (state_q != IDLE);
    assign o_drop  = drop_q;

endmodule
